// File: rtl/note_judge_pkg.sv
// Shared types and helpers for the per-player note judge: FSM states, default J/K/L keymap,
// score width and a saturating adder.
package note_judge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OPEN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int SCORE_W = 16;

    // Lane 2 = J (left), lane 1 = K, lane 0 = L as USB HID usage codes.
    localparam logic [23:0] DEF_LANE_KEYS = {8'h0D, 8'h0E, 8'h0F};

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/note_judge_key_lane_decoder.sv
// Keycode slots to per-lane held vector; purely combinational, zero latency, no backpressure.
// An empty slot (8'h00) never matches a lane.
module key_lane_decoder
    import note_judge_pkg::*;
#(
    parameter int                     NUM_LANES = 3,
    parameter int                     KEY_SLOTS = 2,
    parameter logic [8*NUM_LANES-1:0] LANE_KEYS = DEF_LANE_KEYS
) (
    input  logic [8*KEY_SLOTS-1:0] keycode,
    output logic [NUM_LANES-1:0]   held
);

    always_comb begin
        held = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int s = 0; s < KEY_SLOTS; s++) begin
                if ((keycode[8*s +: 8] != 8'h00) && (keycode[8*s +: 8] == LANE_KEYS[8*l +: 8]))
                    held[l] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_judge.sv
// Per-player note judge: one hit/miss per chart row, registered one cycle after the window closes;
// no backpressure (strobes are never stalled). NOTE_JUDGE_PENALTY_EN makes stray presses force a miss.
module note_judge
    import note_judge_pkg::*;
#(
    parameter int                     NUM_LANES   = 3,
    parameter int                     KEY_SLOTS   = 2,
    parameter logic [8*NUM_LANES-1:0] LANE_KEYS   = DEF_LANE_KEYS,
    parameter int                     DEPTH       = 100,
    parameter int                     WINDOW      = 32,
    parameter int                     HIT_POINTS  = 10,
    parameter int                     COMBO_BONUS = 10,
    localparam int                    ROW_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   start,
    input  logic                   row_strobe,
    input  logic [NUM_LANES-1:0]   chart_row,
    input  logic [8*KEY_SLOTS-1:0] keycode,
    output logic [ROW_W-1:0]       row_idx,
    output logic                   hit,
    output logic                   miss,
    output logic [SCORE_W-1:0]     combo,
    output logic [SCORE_W-1:0]     max_combo,
    output logic [SCORE_W-1:0]     score,
    output logic                   done
);

    localparam int                 WIN_W    = (WINDOW > 1) ? $clog2(WINDOW + 1) : 1;
    localparam logic [SCORE_W-1:0] PTS      = SCORE_W'(HIT_POINTS);
    localparam logic [SCORE_W-1:0] PTS_X2   = SCORE_W'(2 * HIT_POINTS);
    localparam logic [SCORE_W-1:0] BONUS_AT = SCORE_W'(COMBO_BONUS);

    state_t               state, state_nxt;
    logic [NUM_LANES-1:0] held, held_q, press;
    logic [NUM_LANES-1:0] pending, pending_nxt, row_mask;
    logic [WIN_W-1:0]     win_cnt;
    logic                 strobe_pend;
    logic                 bad_nxt;
    logic                 close, is_hit, is_miss, last_row;
    logic                 clr_song, open_row;
    logic [SCORE_W-1:0]   combo_inc;

    key_lane_decoder #(
        .NUM_LANES (NUM_LANES),
        .KEY_SLOTS (KEY_SLOTS),
        .LANE_KEYS (LANE_KEYS)
    ) u_dec (
        .keycode (keycode),
        .held    (held)
    );

    assign press       = held & ~held_q;
    assign pending_nxt = pending & ~press;
    assign last_row    = (row_idx == ROW_W'(DEPTH - 1));

`ifdef NOTE_JUDGE_PENALTY_EN
    logic bad;
    assign bad_nxt = bad | (|(press & ~row_mask));
`else
    assign bad_nxt = 1'b0;
`endif

    assign close   = (state == ST_OPEN) &&
                     ((pending_nxt == '0) || (win_cnt == WIN_W'(WINDOW - 1)) || row_strobe);
    // A stray press outranks the row contents, so even an empty row can miss.
    assign is_miss = bad_nxt || ((row_mask != '0) && (pending_nxt != '0));
    assign is_hit  = !bad_nxt && (row_mask != '0) && (pending_nxt == '0);
    assign combo_inc = (combo == {SCORE_W{1'b1}}) ? combo : combo + 1'b1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_WAIT;
            ST_WAIT: if (row_strobe || strobe_pend) state_nxt = ST_OPEN;
            ST_OPEN: if (close) state_nxt = last_row ? ST_DONE : ST_WAIT;
            ST_DONE: if (start) state_nxt = ST_WAIT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        done     = (state == ST_DONE);
        clr_song = start && ((state == ST_IDLE) || (state == ST_DONE));
        open_row = (state == ST_WAIT) && (row_strobe || strobe_pend);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            held_q      <= '0;
            row_idx     <= '0;
            hit         <= 1'b0;
            miss        <= 1'b0;
            combo       <= '0;
            max_combo   <= '0;
            score       <= '0;
            strobe_pend <= 1'b0;
            pending     <= '0;
            row_mask    <= '0;
            win_cnt     <= '0;
`ifdef NOTE_JUDGE_PENALTY_EN
            bad         <= 1'b0;
`endif
        end else begin
            held_q <= held;
            hit    <= 1'b0;
            miss   <= 1'b0;

            if (clr_song) begin
                row_idx     <= '0;
                combo       <= '0;
                max_combo   <= '0;
                score       <= '0;
                strobe_pend <= 1'b0;
            end

            if (open_row) begin
                pending     <= chart_row;
                row_mask    <= chart_row;
                win_cnt     <= '0;
                strobe_pend <= 1'b0;
`ifdef NOTE_JUDGE_PENALTY_EN
                bad         <= 1'b0;
`endif
            end

            if (state == ST_OPEN) begin
                pending <= pending_nxt;
                win_cnt <= win_cnt + 1'b1;
`ifdef NOTE_JUDGE_PENALTY_EN
                bad     <= bad_nxt;
`endif
                if (close) begin
                    hit  <= is_hit;
                    miss <= is_miss;
                    if (is_hit) begin
                        combo <= combo_inc;
                        score <= sat_add(score, (combo >= BONUS_AT) ? PTS_X2 : PTS);
                        if (combo_inc > max_combo) max_combo <= combo_inc;
                    end else if (is_miss) begin
                        combo <= '0;
                    end
                    if (!last_row)  row_idx     <= row_idx + 1'b1;
                    // The strobe that cut this window belongs to the next row.
                    if (row_strobe) strobe_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_note_judge.sv
// Directed plus randomized rows for note_judge, checked against a row-level reference model.
module tb_note_judge;

    localparam int WIN   = 32;
    localparam int DEPTH = 100;

    logic        Clk = 1'b0;
    logic        Reset, start, row_strobe;
    logic [2:0]  chart_row;
    logic [15:0] keycode;
    logic [6:0]  row_idx;
    logic        hit, miss, done;
    logic [15:0] combo, max_combo, score;

    note_judge dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .row_strobe (row_strobe),
        .chart_row  (chart_row),
        .keycode    (keycode),
        .row_idx    (row_idx),
        .hit        (hit),
        .miss       (miss),
        .combo      (combo),
        .max_combo  (max_combo),
        .score      (score),
        .done       (done)
    );

    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    int m_combo, m_max, m_score, m_row;
    bit m_done;
    bit pen_en;

    // Current row plan: chart, lanes held since before the strobe, and per-lane press interval
    // [r_s, r_e] in OPEN-cycle numbers (r_s = -1: never pressed).
    logic [2:0] r_chart, r_pre;
    int         r_s[3], r_e[3];
    int         r_gap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [7:0] key_of(input int lane);
        return 8'h0F - 8'(lane);
    endfunction

    function automatic logic [15:0] enc(input logic [2:0] h);
        logic [15:0] k;
        bit used;
        k = 16'h0000;
        used = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            if (h[i]) begin
                if (!used) begin
                    k[7:0] = key_of(i);
                    used = 1'b1;
                end else begin
                    k[15:8] = key_of(i);
                end
            end
        end
        return k;
    endfunction

    function automatic logic [2:0] held_at(input int c);
        logic [2:0] h;
        for (int i = 0; i < 3; i++)
            h[i] = r_pre[i] || (r_s[i] >= 0 && r_s[i] <= c && c <= r_e[i]);
        return h;
    endfunction

    // res: 0 = no pulse, 1 = hit, 2 = miss
    task automatic apply(input int res);
        if (res == 1) begin
            m_score = m_score + ((m_combo >= 10) ? 20 : 10);
            if (m_score > 65535) m_score = 65535;
            if (m_combo < 65535) m_combo = m_combo + 1;
            if (m_combo > m_max) m_max = m_combo;
        end else if (res == 2) begin
            m_combo = 0;
        end
        if (m_row == DEPTH - 1) m_done = 1'b1;
        else                    m_row  = m_row + 1;
    endtask

    task automatic chk_state(input string tag, input int res);
        chk({tag, "_hit"},   hit,       (res == 1) ? 1 : 0);
        chk({tag, "_miss"},  miss,      (res == 2) ? 1 : 0);
        chk({tag, "_combo"}, combo,     m_combo);
        chk({tag, "_max"},   max_combo, m_max);
        chk({tag, "_score"}, score,     m_score);
        chk({tag, "_row"},   row_idx,   m_row);
        chk({tag, "_done"},  done,      m_done);
    endtask

    task automatic model_reset();
        m_combo = 0; m_max = 0; m_score = 0; m_row = 0; m_done = 1'b0;
    endtask

    task automatic clear_plan(input logic [2:0] chart);
        r_chart = chart;
        r_pre   = 3'b000;
        r_gap   = 0;
        for (int i = 0; i < 3; i++) begin
            r_s[i] = -1;
            r_e[i] = -1;
        end
    endtask

    // Plays one row from WAIT: gap, strobe, OPEN cycles up to the modelled close, then checks.
    task automatic run_row(output int res);
        int  edge_c[3];
        int  close, c_all;
        bit  cand, bad;
        string tag;
        for (int i = 0; i < 3; i++)
            edge_c[i] = (!r_pre[i] && r_s[i] >= 0) ? r_s[i] : 1000;
        cand = 1'b0;
        if (r_chart == 3'b000) begin
            close = 0;
        end else begin
            c_all = 0;
            for (int i = 0; i < 3; i++)
                if (r_chart[i] && edge_c[i] > c_all) c_all = edge_c[i];
            if (c_all <= WIN - 1) begin
                close = c_all;
                cand  = 1'b1;
            end else begin
                close = WIN - 1;
            end
        end
        bad = 1'b0;
        for (int i = 0; i < 3; i++)
            if (!r_chart[i] && edge_c[i] <= close) bad = 1'b1;
        if (pen_en && bad)          res = 2;
        else if (r_chart == 3'b000) res = 0;
        else                        res = cand ? 1 : 2;

        tag = $sformatf("row%0d", m_row);
        for (int g = 0; g < r_gap; g++) begin
            row_strobe = 1'b0;
            chart_row  = r_chart;
            keycode    = enc(r_pre);
            start      = ($urandom_range(0, 7) == 0);
            cyc();
        end
        start      = 1'b0;
        row_strobe = 1'b1;
        chart_row  = r_chart;
        keycode    = enc(r_pre);
        cyc();
        row_strobe = 1'b0;
        chk({tag, "_quiet"}, {hit, miss}, 0);
        for (int c = 0; c <= close; c++) begin
            keycode = enc(held_at(c));
            cyc();
        end
        apply(res);
        chk_state(tag, res);
    endtask

    task automatic gen_random();
        bit ok;
        int ln;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            clear_plan(3'($urandom_range(0, 7)));
            if ($urandom_range(0, 5) == 0) begin
                ln = $urandom_range(0, 2);
                r_pre[ln] = 1'b1;
            end
            for (int i = 0; i < 3; i++) begin
                if (!r_pre[i] && $urandom_range(0, 99) < (r_chart[i] ? 85 : 15)) begin
                    r_s[i] = $urandom_range(0, WIN + 3);
                    r_e[i] = r_s[i] + $urandom_range(0, 2);
                end
            end
            ok = 1'b1;
            for (int c = 0; c <= WIN; c++)
                if ($countones(held_at(c)) > 2) ok = 1'b0;
        end
        if (!ok) clear_plan(r_chart);
        r_gap = $urandom_range(0, 3);
    endtask

    initial begin
        int res;
        int sc0;
        pen_en = 1'b0;
`ifdef NOTE_JUDGE_PENALTY_EN
        pen_en = 1'b1;
`endif
        Reset = 1'b1; start = 1'b0; row_strobe = 1'b0; chart_row = 3'b000; keycode = 16'h0000;
        model_reset();
        #12;
        chk_state("reset", 0);
        Reset = 1'b0;

        // Strobes and presses in IDLE are ignored.
        row_strobe = 1'b1; chart_row = 3'b100; keycode = 16'h000D;
        cyc(); cyc();
        row_strobe = 1'b0; keycode = 16'h0000;
        cyc();
        chk_state("idle", 0);

        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_state("start", 0);

        // Single-lane hit: J pressed in OPEN cycle 2.
        clear_plan(3'b100); r_s[2] = 2; r_e[2] = 2;
        run_row(res);
        chk("plan_hit", hit, 1);
        chk("plan_combo1", combo, 1);
        chk("plan_score10", score, 10);
        chk("plan_row1", row_idx, 1);

        // Timeout miss after the full window.
        clear_plan(3'b010);
        run_row(res);
        chk("plan_timeout_miss", miss, 1);
        chk("plan_timeout_score", score, 10);

        // Key held from before the strobe has no edge.
        clear_plan(3'b100); r_pre = 3'b100; r_gap = 2;
        run_row(res);
        chk("plan_held_miss", miss, 1);

        // Chord: J at cycle 2 and held, L added at cycle 5.
        clear_plan(3'b101); r_s[2] = 2; r_e[2] = 5; r_s[0] = 5; r_e[0] = 5; r_gap = 1;
        run_row(res);
        chk("plan_chord_hit", hit, 1);

        // J plus stray K in the first OPEN cycle.
        clear_plan(3'b100); r_s[2] = 0; r_e[2] = 0; r_s[1] = 0; r_e[1] = 0;
        run_row(res);
        chk("plan_stray_hit", hit, pen_en ? 0 : 1);
        chk("plan_stray_miss", miss, pen_en ? 1 : 0);

        clear_plan(3'b001);
        run_row(res);

        // Eleven consecutive hits from combo 0: ten at 10 points, the eleventh at 20.
        sc0 = score;
        for (int k = 0; k < 11; k++) begin
            clear_plan(3'($urandom_range(1, 7)));
            for (int i = 0; i < 3; i++) begin
                if (r_chart[i]) begin
                    r_s[i] = 3 * i + $urandom_range(0, 2);
                    r_e[i] = r_s[i];
                end
            end
            r_gap = $urandom_range(0, 2);
            run_row(res);
        end
        chk("plan_bonus_sum", 32'(int'(score) - sc0), 120);
        chk("plan_combo11", combo, 11);

        // Strobe in OPEN cycle 4 cuts a pending row; next row opens two cycles later.
        row_strobe = 1'b0; keycode = 16'h0000; chart_row = 3'b011;
        cyc();
        row_strobe = 1'b1;
        cyc();
        row_strobe = 1'b0;
        repeat (4) cyc();
        row_strobe = 1'b1; chart_row = 3'b100;
        cyc();
        row_strobe = 1'b0;
        apply(2);
        chk_state("cut", 2);
        cyc();
        chk("pend_quiet", {hit, miss}, 0);
        keycode = 16'h000D;
        cyc();
        keycode = 16'h0000;
        apply(1);
        chk_state("pend_open", 1);

        for (int k = 0; k < 200 && !m_done; k++) begin
            gen_random();
            run_row(res);
        end
        chk("song_done", done, 1);
        chk("song_last_row", row_idx, DEPTH - 1);

        // DONE holds its outputs against strobes and presses.
        for (int k = 0; k < 3; k++) begin
            row_strobe = 1'b1; chart_row = 3'b111; keycode = enc(3'(k + 1));
            cyc();
        end
        row_strobe = 1'b0; keycode = 16'h0000;
        cyc();
        chk_state("done_hold", 0);

        start = 1'b1;
        cyc();
        start = 1'b0;
        model_reset();
        chk_state("restart", 0);

        clear_plan(3'b010); r_s[1] = 1; r_e[1] = 1;
        run_row(res);
        chk("restart_score", score, 10);

        // Asynchronous reset mid-window.
        row_strobe = 1'b1; chart_row = 3'b110;
        cyc();
        row_strobe = 1'b0; keycode = 16'h000E;
        cyc();
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        chk_state("arst", 0);
        cyc();
        Reset = 1'b0; keycode = 16'h0000;
        cyc();
        chk_state("post_arst", 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/note_judge.md
# note_judge

Sequential, parametrised per-player note judge for the rhythm game. Decodes USB keycodes into per-lane held/press-edge vectors and opens a timed judgement window per chart row. Issues one hit or miss per non-empty row and maintains combo, max combo and score. It sits between the keyboard keycode path and the scoring/VGA display logic, one instance per player.

## Interface
- NUM_LANES, 3, number of note lanes; chart bit i = lane i.
- KEY_SLOTS, 2, simultaneous keycode slots in `keycode`, 8 bits each.
- LANE_KEYS, {8'h0D,8'h0E,8'h0F}, packed NUM_LANES×8 keycodes; slot i → lane i (lane 2 = J/left, 1 = K, 0 = L). Must be nonzero.
- DEPTH, 100, chart rows per song.
- WINDOW, 32, judgement window length in Clk cycles, ≥1.
- HIT_POINTS, 10, base points per hit.
- COMBO_BONUS, 10, combo at or above which a hit scores 2×HIT_POINTS.
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins song at row 0 (accepted in IDLE/DONE only).
- row_strobe  in  1  pulse from song timer; opens window for current row.
- chart_row  in  NUM_LANES  chart mask at `row_idx`, combinational ROM read.
- keycode  in  8*KEY_SLOTS  current USB keycodes, 8'h00 = empty slot.
- row_idx  out  $clog2(DEPTH)  current chart row.
- hit  out  1  one-cycle pulse, row fully hit.
- miss  out  1  one-cycle pulse, row missed.
- combo  out  16  current combo, saturating.
- max_combo  out  16  best combo this song.
- score  out  16  score, saturating at 16'hFFFF.
- done  out  1  high while in DONE.

## Operation
- Decode: held[i] = any slot equals LANE_KEYS[i]; held_q registered every cycle in all states; press[i] = held[i] & ~held_q[i]. Held keys never count, only edges.
- States: IDLE, WAIT, OPEN, DONE.
- IDLE --start--> WAIT: row_idx, combo, max_combo, score cleared.
- WAIT --row_strobe (or strobe_pend)--> OPEN: latch pending = row = chart_row, win_cnt = 0, clear strobe_pend and bad.
- OPEN each cycle: press lanes in pending are cleared from pending. Close when next pending = 0 or win_cnt == WINDOW-1 or row_strobe.
- On close: row == 0 → neither pulse; else pending ≠ 0 (or bad) → miss; else hit.
- Hit: combo += 1 (saturating), score += HIT_POINTS, or 2×HIT_POINTS if combo (pre-increment) ≥ COMBO_BONUS, saturating. max_combo = max(max_combo, new combo).
- Miss: combo = 0; score unchanged.
- After close: row_idx == DEPTH-1 → DONE, else row_idx += 1 → WAIT.
- row_strobe during OPEN: closes window that cycle and sets strobe_pend; WAIT then opens the next row on the following cycle.
- DONE: outputs hold; start restarts as from IDLE. start in WAIT/OPEN ignored.
- Press in WAIT/IDLE/DONE ignored.

## Timing
- Reset: state IDLE, row_idx 0, hit 0, miss 0, combo 0, max_combo 0, score 0, done 0, held_q 0, strobe_pend 0. Reset mid-song aborts immediately.
- Press visible in the same cycle keycode changes; it clears pending at the next edge.
- Close evaluated in cycle t; hit/miss/combo/score/row_idx update at the edge ending t, visible in t+1.
- Maximum OPEN dwell WINDOW cycles; a row with all lanes pressed in its first OPEN cycle closes after one cycle.
- Chord rows: lanes may be pressed in different cycles within the window.

## Configuration
- NOTE_JUDGE_PENALTY_EN defined: in OPEN, a press on a lane not set in the latched row sets bad; the row closes as miss even if all pending lanes are hit, and an empty row with a stray press produces miss.
- Undefined: presses on non-chart lanes are ignored; bad is never set.

## Structure
- note_judge_pkg: state enum, default LANE_KEYS constant (J/K/L), SCORE_W = 16, saturating-add function.
- Sub-module key_lane_decoder: combinational keycode → held vector, parametrised by NUM_LANES, KEY_SLOTS, LANE_KEYS.

## Test plan
- Reset, start, row_strobe with chart_row 3'b100, keycode 16'h000D three cycles later → hit pulse, combo 1, score 10, row_idx 1.
- chart_row 3'b010, no key for WINDOW cycles → miss on the cycle after win_cnt reaches 31; combo 0; score unchanged.
- Hold 16'h000D from before strobe through window, chart_row 3'b100 → miss (no edge).
- Chord 3'b101: 16'h000D at cycle 2, 16'h0F0D at cycle 5 → single hit at cycle 6; 11 consecutive hits → score 10×10 + 20 = 120.
- row_strobe in OPEN cycle 4 with pending lanes → miss, next row opens two cycles later; row DEPTH-1 close → done = 1, start restarts at row 0.
- NOTE_JUDGE_PENALTY_EN: chart_row 3'b100, keycodes 16'h0E0D → miss; undefined → hit.
